alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter sharing one ALU, with a single-entry response register.
module alu_core (
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_o,
  output logic        err_o
);
  always_comb begin
    res_o = '0;
    err_o = 1'b0;
    case (op_i)
      4'h0: res_o = a_i + b_i;
      4'h1: res_o = a_i - b_i;
      4'h2: res_o = a_i & b_i;
      4'h3: res_o = a_i | b_i;
      4'h4: res_o = a_i ^ b_i;
      4'h5: res_o = {31'b0, $signed(a_i) < $signed(b_i)};
      4'h6: res_o = {31'b0, a_i < b_i};
      4'h7: res_o = a_i << b_i[4:0];
      4'h8: res_o = a_i >> b_i[4:0];
      4'h9: res_o = $signed(a_i) >>> b_i[4:0];
      4'ha: res_o = (a_i + b_i) & ~32'd1;
      default: err_o = 1'b1;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter bit RESET_FAVOUR = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_zero,
  output logic        resp_err
);
  typedef enum logic {EMPTY, FULL} state_e;
  state_e      state_q;
  logic        fav_q, id_q, zero_q, err_q;
  logic [31:0] result_q;
  logic        can_accept, contended, gnt0, gnt1;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;
  logic        alu_err;
  always_comb begin
    can_accept = !rst && (state_q == EMPTY || resp_ready);
    contended  = req0_valid && req1_valid;
    gnt0       = can_accept && req0_valid && (!req1_valid || !fav_q);
    gnt1       = can_accept && req1_valid && (!req0_valid || fav_q);
    alu_a      = gnt1 ? req1_a : req0_a;
    alu_b      = gnt1 ? req1_b : req0_b;
    alu_op     = gnt1 ? req1_op : req0_op;
  end
  alu_core u_alu (
    .op_i  (alu_op),
    .a_i   (alu_a),
    .b_i   (alu_b),
    .res_o (alu_res),
    .err_o (alu_err)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      fav_q    <= RESET_FAVOUR;
      id_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (gnt0 || gnt1) begin
      state_q  <= FULL;
      id_q     <= gnt1;
      result_q <= alu_res;
      zero_q   <= (alu_res == '0);
      err_q    <= alu_err;
      if (contended) fav_q <= ~fav_q;
    end else if (resp_ready) begin
      state_q <= EMPTY;
    end
  end
  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign resp_valid  = (state_q == FULL);
  assign resp_id     = id_q;
  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign resp_err    = err_q;
endmodule
